rc4_ksa_swap: RTL and testbench

Parametrised RC4 key-scheduling swap loop: for i = 0..ITERATIONS-1 it computes j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i]/S[j] in an external single-port S-box RAM. It runs after the S-box identity-fill loop and before the keystream/decrypt stage. It supports arbitrary key length, iteration count and RAM read latency, with a four-phase start/done handshake.

---
 rtl/rc4_pkg.sv | 19 +
 rtl/rc4_key_byte_sel.sv | 23 ++
 rtl/rc4_ksa_swap.sv | 174 +++++++++++++++++
 tb/tb_rc4_ksa_swap.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 types: S-box byte type, S-box depth and the key-scheduling FSM states.
// The S-box fill and keystream blocks use the same definitions.
package rc4_pkg;

    typedef logic [7:0] byte_t;

    localparam int SBOX_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_I   = 3'd1,
        CALC_J = 3'd2,
        RD_J   = 3'd3,
        WR_J   = 3'd4,
        WR_I   = 3'd5,
        DONE   = 3'd6
    } ksa_state_t;

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Picks byte kidx out of a KEY_BYTES-wide key; byte 0 is the most significant byte.
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    localparam int KIDX_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
    input  logic [KEY_BYTES*8-1:0] key,
    input  logic [KIDX_W-1:0]      kidx,
    output byte_t                  key_byte
);

    // A one-hot style mux avoids a variable part-select on the key.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KIDX_W'(k)) begin
                key_byte = key[(KEY_BYTES-1-k)*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/rc4_ksa_swap.sv
// RC4 key-scheduling swap loop over an external single-port S-box RAM.
// Define RC4_KSA_DBG_EN to expose i, j, si and sj on dbg_* ports.
module rc4_ksa_swap
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES  = 3,
    parameter int ITERATIONS = 256,
    parameter int RD_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] secret_key,
    input  byte_t                  rd_data,
    output byte_t                  address,
    output byte_t                  data,
    output logic                   wren,
    output logic                   busy,
    output logic                   done
`ifdef RC4_KSA_DBG_EN
    ,
    output byte_t                  dbg_i,
    output byte_t                  dbg_j,
    output byte_t                  dbg_si,
    output byte_t                  dbg_sj
`endif
);

    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int CNT_W  = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    ksa_state_t        state_q, state_d;
    byte_t             i_q, i_d;
    byte_t             j_q, j_d;
    byte_t             si_q, si_d;
    byte_t             sj_q, sj_d;
    logic [KIDX_W-1:0] kidx_q, kidx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    byte_t             key_byte;

    rc4_key_byte_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .key      (secret_key),
        .kidx     (kidx_q),
        .key_byte (key_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        kidx_d  = kidx_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    cnt_d   = '0;
                    wait_d  = '0;
                    state_d = RD_I;
                end
            end
            // Address is held for RD_LATENCY cycles; the RAM output is taken on the last one.
            RD_I: begin
                if (wait_q == WAIT_W'(RD_LATENCY-1)) begin
                    si_d    = rd_data;
                    wait_d  = '0;
                    state_d = CALC_J;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            CALC_J: begin
                j_d     = j_q + si_q + key_byte;
                state_d = RD_J;
            end
            RD_J: begin
                if (wait_q == WAIT_W'(RD_LATENCY-1)) begin
                    sj_d    = rd_data;
                    wait_d  = '0;
                    state_d = WR_J;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WR_J: begin
                state_d = WR_I;
            end
            WR_I: begin
                i_d    = i_q + 8'd1;
                kidx_d = (kidx_q == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx_q + KIDX_W'(1);
                if (cnt_q == CNT_W'(ITERATIONS-1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = RD_I;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A self-swap (i == j) writes si to the same location twice, leaving S unchanged.
    always_comb begin
        address = i_q;
        data    = '0;
        wren    = 1'b0;
        case (state_q)
            RD_J: begin
                address = j_q;
            end
            WR_J: begin
                address = j_q;
                data    = si_q;
                wren    = 1'b1;
            end
            WR_I: begin
                data = sj_q;
                wren = 1'b1;
            end
            default: begin
                address = i_q;
            end
        endcase
    end

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);

`ifdef RC4_KSA_DBG_EN
    assign dbg_i  = i_q;
    assign dbg_j  = j_q;
    assign dbg_si = si_q;
    assign dbg_sj = sj_q;
`endif

endmodule

// File: tb/tb_rc4_ksa_swap.sv
// Scoreboard bench: two DUTs (default timing, and a short 1-cycle-latency build),
// each with its own S-box RAM model; expected RAM writes are queued at each start.
`timescale 1ns/1ps
module tb_rc4_ksa_swap;

    localparam int KB   = 3;
    localparam int IT0  = 256;
    localparam int LAT0 = 2;
    localparam int IT1  = 4;
    localparam int LAT1 = 1;

    typedef struct {
        int inst;
        int edge_n;
        int a;
        int d;
    } wr_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0]       st    = '0;
    logic [1:0]       fill  = '0;
    logic [1:0][23:0] key   = '0;
    logic [1:0][7:0]  rd, ad, da;
    logic [1:0]       we, bs, dn;
`ifdef RC4_KSA_DBG_EN
    logic [1:0][7:0]  dbi, dbj, dbsi, dbsj;
`endif

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] raq0;
    logic [7:0] exp_s [256];

    int   cyc = 0, t0 = 0, checks = 0, errors = 0, nwr = 0;
    int   obs_a [2], obs_d [2], obs_e [2];
    wr_t  q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rc4_ksa_swap #(.KEY_BYTES(KB), .ITERATIONS(IT0), .RD_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .secret_key(key[0]), .rd_data(rd[0]),
        .address(ad[0]), .data(da[0]), .wren(we[0]), .busy(bs[0]), .done(dn[0])
`ifdef RC4_KSA_DBG_EN
        , .dbg_i(dbi[0]), .dbg_j(dbj[0]), .dbg_si(dbsi[0]), .dbg_sj(dbsj[0])
`endif
    );

    rc4_ksa_swap #(.KEY_BYTES(KB), .ITERATIONS(IT1), .RD_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .secret_key(key[1]), .rd_data(rd[1]),
        .address(ad[1]), .data(da[1]), .wren(we[1]), .busy(bs[1]), .done(dn[1])
`ifdef RC4_KSA_DBG_EN
        , .dbg_i(dbi[1]), .dbg_j(dbj[1]), .dbg_si(dbsi[1]), .dbg_sj(dbsj[1])
`endif
    );

    // Two-cycle RAM: address registered, data read combinationally from the register.
    always @(posedge clk) begin
        if (fill[0]) begin
            for (int k = 0; k < 256; k++) mem0[k] <= 8'(k);
        end else if (we[0]) begin
            mem0[ad[0]] <= da[0];
        end
        raq0 <= ad[0];
    end
    assign rd[0] = mem0[raq0];

    // One-cycle RAM: combinational read.
    always @(posedge clk) begin
        if (fill[1]) begin
            for (int k = 0; k < 256; k++) mem1[k] <= 8'(k);
        end else if (we[1]) begin
            mem1[ad[1]] <= da[1];
        end
    end
    assign rd[1] = mem1[ad[1]];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic int memrd(input int g, input int x);
        return (g == 1) ? int'(mem1[x]) : int'(mem0[x]);
    endfunction

    // Monitor: every RAM write is matched against the head of the queue.
    always @(negedge clk) begin : mon
        wr_t e;
        int  g;
        if (rst_n && (we != 2'b00)) begin
            g = we[1] ? 1 : 0;
            if (nwr < 2) begin
                obs_a[nwr] = int'(ad[g]);
                obs_d[nwr] = int'(da[g]);
                obs_e[nwr] = cyc - t0 + 1;
            end
            nwr++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected addr=%0h data=%0h required=no write", ad[g], da[g]);
            end else begin
                e = q.pop_front();
                chk("wr_inst", g, e.inst);
                chk("wr_edge", cyc - t0 + 1, e.edge_n);
                chk("wr_addr", int'(ad[g]), e.a);
                chk("wr_data", int'(da[g]), e.d);
            end
        end
    end

    task automatic refill(input int g);
        @(negedge clk);
        fill[g] = 1'b1;
        @(negedge clk);
        fill[g] = 1'b0;
    endtask

    // Queues the golden KSA write stream (from identity S), raises start and waits for done.
    // abort_at >= 0 pulls reset at that edge offset instead of completing the run.
    task automatic run(input int g, input logic [23:0] k, input int iters,
                       input int lat, input int abort_at);
        int         per, j, busy_n, dedge, mism;
        logic [7:0] ms [256];
        logic [7:0] t;
        per = 2*lat + 3; j = 0; busy_n = 0; dedge = -1; mism = 0;
        for (int x = 0; x < 256; x++) ms[x] = 8'(x);
        @(negedge clk);
        key[g] = k;
        t0  = cyc + 1;
        nwr = 0;
        for (int i = 0; i < iters; i++) begin
            j = (j + int'(ms[i]) + int'(k[8*(KB-1-(i % KB)) +: 8])) % 256;
            q.push_back('{g, i*per + per - 1, j, int'(ms[i])});
            q.push_back('{g, i*per + per, i, int'(ms[j])});
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
        end
        exp_s = ms;
        st[g] = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (abort_at >= 0 && (cyc - t0) == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_addr", int'(ad[g]), 0);
                chk("rst_mid_data", int'(da[g]), 0);
                chk("rst_mid_wren", int'(we[g]), 0);
                chk("rst_mid_busy", int'(bs[g]), 0);
                chk("rst_mid_done", int'(dn[g]), 0);
                q.delete();
                st[g] = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (dn[g]) begin
                dedge = cyc - t0 + 1;
                break;
            end
            if (bs[g]) busy_n++;
        end
        chk("done_edge", dedge, iters*per + 1);
        chk("busy_cycles", busy_n, iters*per);
        chk("queue_drained", q.size(), 0);
        for (int x = 0; x < 256; x++) if (memrd(g, x) != int'(exp_s[x])) mism++;
        chk("final_sbox_mismatches", mism, 0);
    endtask

    task automatic hold_drop(input int g, input int hold);
        for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            chk("done_hold", int'(dn[g]), 1);
            chk("busy_in_done", int'(bs[g]), 0);
        end
        st[g] = 1'b0;
        @(negedge clk);
        chk("done_fall", int'(dn[g]), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_addr", int'(ad[g]), 0);
            chk("rst_data", int'(da[g]), 0);
            chk("rst_wren", int'(we[g]), 0);
            chk("rst_busy", int'(bs[g]), 0);
            chk("rst_done", int'(dn[g]), 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Key 010203: first swap is S[0]<->S[1] (j = 1), writes at edges 6 and 7.
        refill(0);
        run(0, 24'h010203, IT0, LAT0, -1);
        chk("first_wrj_addr", obs_a[0], 1);
        chk("first_wrj_data", obs_d[0], 0);
        chk("first_wrj_edge", obs_e[0], 6);
        chk("first_wri_addr", obs_a[1], 0);
        chk("first_wri_data", obs_d[1], 1);
        chk("first_wri_edge", obs_e[1], 7);
        hold_drop(0, 0);

        // All-zero key, full run; start held after done, then dropped, then a second run.
        refill(0);
        run(0, 24'h000000, IT0, LAT0, -1);
        hold_drop(0, 4);
        refill(0);
        run(0, 24'h000000, IT0, LAT0, -1);
        hold_drop(0, 0);

        // Reset during RD_J of iteration 10 (edges 73..74), then refill and rerun.
        refill(0);
        run(0, 24'h1A2B3C, IT0, LAT0, 73);
        refill(0);
        run(0, 24'h1A2B3C, IT0, LAT0, -1);
        hold_drop(0, 0);

        // Short build, key 00FF01: self-swap at i=0, kidx wraps at i=3 (j = 0,0,3,5).
        refill(1);
        run(1, 24'h00FF01, IT1, LAT1, -1);
        chk("short_s0", memrd(1, 0), 1);
        chk("short_s1", memrd(1, 1), 0);
        chk("short_s2", memrd(1, 2), 3);
        chk("short_s3", memrd(1, 3), 5);
        chk("short_s4", memrd(1, 4), 4);
        chk("short_s5", memrd(1, 5), 2);
        hold_drop(1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
